lcd_field_fmt: RTL and testbench

- Sequential number-to-text formatter that owns the two 16-character LCD row buffers (`row_A`, `row_B`) consumed by `LCD_module`.
- Generalises the fixed per-cycle hex field writes into a request-driven engine: arbitrary row, column, digit count, hex or decimal mode.
- Producers (game state, control code, score) post fields over a valid/ready handshake; the block writes them into the row buffers one character per cycle.

---
 rtl/lcd_field_fmt_if.sv | 25 ++
 rtl/lcd_field_fmt.sv | 170 +++++++++++++++++
 tb/tb_lcd_field_fmt.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_field_fmt_if.sv
// Field request channel into lcd_field_fmt: valid/ready request bus plus done pulse.
interface lcd_field_fmt_if #(
  parameter int unsigned VAL_W = 16,
  parameter int unsigned COL_W = 4,
  parameter int unsigned DIG_W = 3
) ();
  logic             req_valid;
  logic             req_ready;
  logic [VAL_W-1:0] req_value;
  logic             req_row;
  logic [COL_W-1:0] req_col;
  logic [DIG_W-1:0] req_digits;
  logic             req_dec;
  logic             done;

  modport master (
    output req_valid, req_value, req_row, req_col, req_digits, req_dec,
    input  req_ready, done
  );

  modport slave (
    input  req_valid, req_value, req_row, req_col, req_digits, req_dec,
    output req_ready, done
  );
endinterface

// File: rtl/lcd_field_fmt.sv
// Request-driven hex/decimal field formatter owning the two LCD row buffers.
// One character written per cycle; decimal requests first run a double-dabble
// conversion. Optional macro LCD_FIELD_LEADING_BLANK_EN blanks leading zeros
// in decimal fields.
module lcd_field_fmt #(
  parameter int unsigned VAL_W      = 16,
  parameter int unsigned MAX_DIGITS = 5,
  parameter int unsigned COLS       = 16,
  parameter logic [7:0]  FILL_CHAR  = 8'h3F
) (
  input  logic                clk,
  input  logic                reset_n,
  lcd_field_fmt_if.slave      bus,
  output logic [8*COLS-1:0]   row_A,
  output logic [8*COLS-1:0]   row_B
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DIG_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned BCD_W = 4 * MAX_DIGITS;
  localparam int unsigned CNT_W = $clog2(VAL_W + MAX_DIGITS + 1);
  localparam int unsigned CE_W  = $clog2(COLS + MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, EMIT, FIN} state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       row_a_q [COLS];
  logic [7:0]       row_a_d [COLS];
  logic [7:0]       row_b_q [COLS];
  logic [7:0]       row_b_d [COLS];
`ifdef LCD_FIELD_LEADING_BLANK_EN
  logic             lead_q, lead_d;
`endif

  logic [DIG_W-1:0] req_dig;
  logic [DIG_W-1:0] dig_idx;
  logic [3:0]       nib;
  logic [7:0]       ch;
  logic [CE_W-1:0]  wcol;
  logic [BCD_W-1:0] bcd_t;

  // Clamp the requested width to the supported maximum.
  always_comb begin
    req_dig = bus.req_digits;
    if (bus.req_digits > DIG_W'(MAX_DIGITS)) req_dig = DIG_W'(MAX_DIGITS);
  end

  // Next-state, datapath and row-buffer update.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    row_d   = row_q;
    col_d   = col_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    row_a_d = row_a_q;
    row_b_d = row_b_q;
`ifdef LCD_FIELD_LEADING_BLANK_EN
    lead_d  = lead_q;
`endif
    dig_idx = DIG_W'(dig_q - DIG_W'(1) - DIG_W'(cnt_q));
    nib     = bcd_q[4*dig_idx +: 4];
    ch      = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    wcol    = CE_W'(col_q) + CE_W'(cnt_q);
    bcd_t   = bcd_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          val_d = bus.req_value;
          row_d = bus.req_row;
          col_d = bus.req_col;
          dig_d = req_dig;
          cnt_d = '0;
`ifdef LCD_FIELD_LEADING_BLANK_EN
          lead_d = bus.req_dec;
`endif
          if (bus.req_dec) bcd_d = '0;
          else             bcd_d = BCD_W'(bus.req_value);
          if (req_dig == '0)     state_d = FIN;
          else if (bus.req_dec)  state_d = CONV;
          else                   state_d = EMIT;
        end
      end
      CONV: begin
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
          if (bcd_t[4*i +: 4] >= 4'd5) bcd_t[4*i +: 4] = bcd_t[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_t[BCD_W-2:0], val_q[VAL_W-1]};
        val_d = {val_q[VAL_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          cnt_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
`ifdef LCD_FIELD_LEADING_BLANK_EN
        if (lead_q && (nib == 4'd0) && (dig_idx != '0)) ch = 8'h20;
        else                                             lead_d = 1'b0;
`endif
        if (wcol < CE_W'(COLS)) begin
          if (row_q) row_b_d[COL_W'(wcol)] = ch;
          else       row_a_d[COL_W'(wcol)] = ch;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(dig_q) - CNT_W'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == FIN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      val_q   <= '0;
      bcd_q   <= '0;
      row_q   <= 1'b0;
      col_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      row_a_q <= '{default: FILL_CHAR};
      row_b_q <= '{default: FILL_CHAR};
`ifdef LCD_FIELD_LEADING_BLANK_EN
      lead_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      row_a_q <= row_a_d;
      row_b_q <= row_b_d;
`ifdef LCD_FIELD_LEADING_BLANK_EN
      lead_q  <= lead_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;

  // Pack the cell registers onto the row outputs, column 0 leftmost.
  for (genvar c = 0; c < int'(COLS); c++) begin : g_pack
    assign row_A[8*(COLS-1-c) +: 8] = row_a_q[c];
    assign row_B[8*(COLS-1-c) +: 8] = row_b_q[c];
  end

endmodule

// File: tb/tb_lcd_field_fmt.sv
// Directed bench for lcd_field_fmt with hand-computed expected row contents.
module tb_lcd_field_fmt;

  logic         clk;
  logic         reset_n;
  logic [127:0] row_A;
  logic [127:0] row_B;
  logic [7:0]   exp_a [16];
  logic [7:0]   exp_b [16];
  int           n_checks;
  int           n_pass;

  lcd_field_fmt_if #(.VAL_W(16), .COL_W(4), .DIG_W(3)) bus ();

  lcd_field_fmt #(.VAL_W(16), .MAX_DIGITS(5), .COLS(16), .FILL_CHAR(8'h3F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .row_A   (row_A),
    .row_B   (row_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pack_row(input logic r);
    logic [127:0] p;
    for (int c = 0; c < 16; c++) p[8*(15-c) +: 8] = r ? exp_b[c] : exp_a[c];
    return p;
  endfunction

  task automatic fill_exp();
    for (int c = 0; c < 16; c++) begin
      exp_a[c] = 8'h3F;
      exp_b[c] = 8'h3F;
    end
  endtask

  task automatic send(input logic [15:0] v, input logic r, input logic [3:0] c,
                      input logic [2:0] d, input logic dec);
    bus.req_value  = v;
    bus.req_row    = r;
    bus.req_col    = c;
    bus.req_digits = d;
    bus.req_dec    = dec;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Counts negedges after the acceptance edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fill_exp();
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else n_pass++;
    n_checks++;
    if (row_A !== pack_row(0) || row_B !== pack_row(1))
      $display("FAIL reset_rows: got %h %h want all 3f", row_A, row_B);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hex();
    int n;
    send(16'h00A7, 1'b0, 4'd0, 3'd2, 1'b0);
    wait_done(n);
    exp_a[0] = 8'h41; exp_a[1] = 8'h37;
    n_checks++;
    if (n !== 3) $display("FAIL hex_latency: got %0d want 3", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL hex_done_pulse: got done=%b ready=%b want done=0 ready=1", bus.done, bus.req_ready);
    else n_pass++;
    n_checks++;
    if (row_A !== pack_row(0)) $display("FAIL hex_row_a: got %h want %h", row_A, pack_row(0));
    else n_pass++;
    n_checks++;
    if (row_B !== pack_row(1)) $display("FAIL hex_row_b: got %h want %h", row_B, pack_row(1));
    else n_pass++;
  endtask

  task automatic test_dec();
    int n;
    send(16'd1234, 1'b1, 4'd8, 3'd5, 1'b1);
    wait_done(n);
`ifdef LCD_FIELD_LEADING_BLANK_EN
    exp_b[8] = 8'h20;
`else
    exp_b[8] = 8'h30;
`endif
    exp_b[9] = 8'h31; exp_b[10] = 8'h32; exp_b[11] = 8'h33; exp_b[12] = 8'h34;
    n_checks++;
    if (n !== 22) $display("FAIL dec_latency: got %0d want 22", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_B !== pack_row(1)) $display("FAIL dec_row_b: got %h want %h", row_B, pack_row(1));
    else n_pass++;
    n_checks++;
    if (row_A !== pack_row(0)) $display("FAIL dec_row_a: got %h want %h", row_A, pack_row(0));
    else n_pass++;
  endtask

  task automatic test_clip();
    int n;
    send(16'hBEEF, 1'b0, 4'd14, 3'd4, 1'b0);
    wait_done(n);
    exp_a[14] = 8'h42; exp_a[15] = 8'h45;
    n_checks++;
    if (n !== 5) $display("FAIL clip_latency: got %0d want 5", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_A !== pack_row(0)) $display("FAIL clip_row_a: got %h want %h", row_A, pack_row(0));
    else n_pass++;
    n_checks++;
    if (row_B !== pack_row(1)) $display("FAIL clip_row_b: got %h want %h", row_B, pack_row(1));
    else n_pass++;
  endtask

  task automatic test_trunc();
    int n;
    send(16'd65535, 1'b0, 4'd4, 3'd3, 1'b1);
    wait_done(n);
    exp_a[4] = 8'h35; exp_a[5] = 8'h33; exp_a[6] = 8'h35;
    n_checks++;
    if (n !== 20) $display("FAIL trunc_latency: got %0d want 20", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_A !== pack_row(0)) $display("FAIL trunc_row_a: got %h want %h", row_A, pack_row(0));
    else n_pass++;
  endtask

  task automatic test_zero_digits();
    int n;
    send(16'h1234, 1'b1, 4'd0, 3'd0, 1'b0);
    wait_done(n);
    n_checks++;
    if (n !== 1) $display("FAIL zero_digits_latency: got %0d want 1", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_A !== pack_row(0) || row_B !== pack_row(1))
      $display("FAIL zero_digits_rows: got %h %h want %h %h", row_A, row_B, pack_row(0), pack_row(1));
    else n_pass++;
  endtask

  task automatic test_clamp();
    int n;
    send(16'h1234, 1'b1, 4'd0, 3'd7, 1'b0);
    wait_done(n);
    exp_b[0] = 8'h30; exp_b[1] = 8'h31; exp_b[2] = 8'h32; exp_b[3] = 8'h33; exp_b[4] = 8'h34;
    n_checks++;
    if (n !== 6) $display("FAIL clamp_latency: got %0d want 6", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_B !== pack_row(1)) $display("FAIL clamp_row_b: got %h want %h", row_B, pack_row(1));
    else n_pass++;
  endtask

  task automatic test_dec_zero();
    int n;
    send(16'd0, 1'b0, 4'd8, 3'd3, 1'b1);
    wait_done(n);
`ifdef LCD_FIELD_LEADING_BLANK_EN
    exp_a[8] = 8'h20; exp_a[9] = 8'h20;
`else
    exp_a[8] = 8'h30; exp_a[9] = 8'h30;
`endif
    exp_a[10] = 8'h30;
    n_checks++;
    if (n !== 20) $display("FAIL dec_zero_latency: got %0d want 20", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_A !== pack_row(0)) $display("FAIL dec_zero_row_a: got %h want %h", row_A, pack_row(0));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    int extra;
    bus.req_value  = 16'h00C3;
    bus.req_row    = 1'b1;
    bus.req_col    = 4'd14;
    bus.req_digits = 3'd2;
    bus.req_dec    = 1'b0;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_value  = 16'h005E;
    bus.req_col    = 4'd12;
    wait_done(n);
    n_checks++;
    if (n !== 3 || bus.req_ready !== 1'b0)
      $display("FAIL b2b_first_done: got lat=%0d ready=%b want lat=3 ready=0", n, bus.req_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_return: got %b want 1", bus.req_ready);
    else n_pass++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_done(n);
    n_checks++;
    if (n !== 3) $display("FAIL b2b_second_latency: got %0d want 3", n);
    else n_pass++;
    exp_b[14] = 8'h43; exp_b[15] = 8'h33;
    exp_b[12] = 8'h35; exp_b[13] = 8'h45;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL b2b_duplicate: got %0d extra done pulses want 0", extra);
    else n_pass++;
    n_checks++;
    if (row_B !== pack_row(1)) $display("FAIL b2b_row_b: got %h want %h", row_B, pack_row(1));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    send(16'd999, 1'b0, 4'd0, 3'd3, 1'b1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    fill_exp();
    n_checks++;
    if (row_A !== pack_row(0) || row_B !== pack_row(1))
      $display("FAIL midreset_rows: got %h %h want all 3f", row_A, row_B);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL midreset_flags: got ready=%b done=%b want ready=1 done=0", bus.req_ready, bus.done);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL midreset_no_done: got %0d done pulses want 0", seen);
    else n_pass++;
    n_checks++;
    if (row_A !== pack_row(0) || row_B !== pack_row(1))
      $display("FAIL midreset_no_write: got %h %h want all 3f", row_A, row_B);
    else n_pass++;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_value  = '0;
    bus.req_row    = 1'b0;
    bus.req_col    = '0;
    bus.req_digits = '0;
    bus.req_dec    = 1'b0;
    test_reset();
    test_hex();
    test_dec();
    test_clip();
    test_trunc();
    test_zero_digits();
    test_clamp();
    test_dec_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
